// File: rtl/efuse_pkg.sv
// efuse_pkg: shared types and constants for the efuse access arbiter.
//   state_e   - arbiter FSM states
//   tag_t     - read owner tag; MSB set = register-mode owner, low bits =
//               requester channel index (sized for the largest NCH of 8)
//   GAP_CYCLES - idle cycles inserted between two owners
package efuse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_REG   = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int MAX_NCH = 8;
  localparam int TAG_W   = $clog2(MAX_NCH) + 1;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t TAG_REG = {1'b1, {(TAG_W-1){1'b0}}};

  localparam int GAP_CYCLES = 1;

  function automatic logic tag_is_reg(input tag_t t);
    return t[TAG_W-1];
  endfunction

endpackage

// File: rtl/efuse_rr_arb.sv
// efuse_rr_arb: NCH-wide round-robin picker.
//   req_i    - per-channel requests
//   take_i   - the pick is consumed this cycle; pointer moves past it
//   vld_o    - at least one request present
//   idx_o    - picked channel index
//   gnt_oh_o - picked channel, one-hot
// The pointer names the channel searched first; reset makes it channel 0.
module efuse_rr_arb #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req_i,
  input  logic           take_i,
  output logic           vld_o,
  output logic [IW-1:0]  idx_o,
  output logic [NCH-1:0] gnt_oh_o
);

  logic [IW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] hi_req;
  logic [IW-1:0]  hi_idx, any_idx;

  // Lowest request at or above the pointer wins; otherwise wrap to the
  // lowest request overall.
  always_comb begin
    hi_req  = '0;
    hi_idx  = '0;
    any_idx = '0;
    for (int i = 0; i < NCH; i++) hi_req[i] = req_i[i] && (i >= int'(ptr_q));
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hi_req[i]) hi_idx  = IW'(i);
      if (req_i[i])  any_idx = IW'(i);
    end
    vld_o    = |req_i;
    idx_o    = (|hi_req) ? hi_idx : any_idx;
    gnt_oh_o = vld_o ? (NCH'(1) << idx_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i && vld_o) ptr_d = (int'(idx_o) == NCH - 1) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/efuse_arb.sv
// efuse_arb: arbitrates NCH requesters plus a register-mode override onto a
// single efuse macro port.
//   req_i/pgmen_i/rden_i/aen_i/addr_i - per-channel request and strobes
//   gnt_o                             - registered one-hot grant
//   rdata_o/rvalid_o                  - shared read data, per-channel pulse
//   err_o                             - pulse on pgmen+rden both selected
//   rg_*                              - register-mode override path
//   efuse_*_o / efuse_rdata_i         - macro port, strobes registered once
//   scan_mode                         - zeroes macro outputs, blocks launches
// Reads are tracked by pushing an owner tag into an RD_LAT-deep pipeline on
// every aen rising edge seen with rden; the tag decides who gets the data.
module efuse_arb
  import efuse_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_mode,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    pgmen_i,
  input  logic [NCH-1:0]    rden_i,
  input  logic [NCH-1:0]    aen_i,
  input  logic [NCH*AW-1:0] addr_i,
  output logic [NCH-1:0]    gnt_o,
  output logic [DW-1:0]     rdata_o,
  output logic [NCH-1:0]    rvalid_o,
  output logic              err_o,
  input  logic              rg_reg_mode,
  input  logic              rg_pgmen,
  input  logic              rg_rden,
  input  logic              rg_aen,
  input  logic [AW-1:0]     rg_addr,
  output logic [DW-1:0]     rg_rdata,
  output logic              rg_rvalid,
  output logic              efuse_pgmen_o,
  output logic              efuse_rden_o,
  output logic              efuse_aen_o,
  output logic [AW-1:0]     efuse_addr_o,
  input  logic [DW-1:0]     efuse_rdata_i
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  // FSM / grant
  state_e         state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [1:0]     gap_cnt_q, gap_cnt_d;

  // Picker
  logic           pick_vld, pick_take;
  logic [IW-1:0]  pick_idx;
  logic [NCH-1:0] pick_oh;

  // Selected strobes and macro output register
  logic           sel_pgmen, sel_rden, sel_aen, illegal;
  logic [AW-1:0]  sel_addr;
  tag_t           sel_tag;
  logic [AW-1:0]  ch_addr [NCH];

  logic           pgmen_q, pgmen_d, rden_q, rden_d, aen_q, aen_d, aen_prev_q;
  logic [AW-1:0]  addr_q, addr_d;
  tag_t           tag_q, tag_d;
  logic           err_q, err_d;

  // Read tag pipeline and capture
  logic                    launch;
  logic [RD_LAT-1:0]       vld_pipe_q, vld_pipe_d;
  tag_t [RD_LAT-1:0]       tag_pipe_q, tag_pipe_d;
  logic                    exit_vld;
  tag_t                    exit_tag;
  logic [DW-1:0]           rdata_q, rdata_d, rg_rdata_q, rg_rdata_d;
  logic [NCH-1:0]          rvalid_q, rvalid_d;
  logic                    rg_rvalid_q, rg_rvalid_d;

  for (genvar k = 0; k < NCH; k++) begin : g_addr
    assign ch_addr[k] = addr_i[k*AW +: AW];
  end

  efuse_rr_arb #(.NCH(NCH), .IW(IW)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .take_i   (pick_take),
    .vld_o    (pick_vld),
    .idx_o    (pick_idx),
    .gnt_oh_o (pick_oh)
  );

  // Register mode wins in IDLE but never cuts an active channel grant.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    gap_cnt_d = gap_cnt_q;
    pick_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gap_cnt_d = '0;
        if (rg_reg_mode) begin
          state_d = ST_REG;
        end else if (pick_vld) begin
          state_d   = ST_GRANT;
          owner_d   = pick_idx;
          gnt_d     = pick_oh;
          pick_take = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!req_i[owner_q]) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          gap_cnt_d = '0;
        end
      end
      ST_REG: begin
        if (!rg_reg_mode) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 2'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                                 gap_cnt_d = gap_cnt_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe mux; the owner tag travels with the strobes so a launch seen on
  // the registered outputs is attributed to whoever drove it.
  always_comb begin
    sel_pgmen = 1'b0;
    sel_rden  = 1'b0;
    sel_aen   = 1'b0;
    sel_addr  = '0;
    sel_tag   = '0;
    case (state_q)
      ST_GRANT: begin
        sel_pgmen = pgmen_i[owner_q];
        sel_rden  = rden_i[owner_q];
        sel_aen   = aen_i[owner_q];
        sel_addr  = ch_addr[owner_q];
        sel_tag   = tag_t'(owner_q);
      end
      ST_REG: begin
        sel_pgmen = rg_pgmen;
        sel_rden  = rg_rden;
        sel_aen   = rg_aen;
        sel_addr  = rg_addr;
        sel_tag   = TAG_REG;
      end
      default: ;
    endcase
    // Program and read together would corrupt the fuse array: drop both.
    illegal = sel_pgmen & sel_rden;
    pgmen_d = sel_pgmen & ~illegal;
    rden_d  = sel_rden & ~illegal;
    aen_d   = sel_aen;
    addr_d  = sel_addr;
    tag_d   = sel_tag;
    err_d   = illegal;
  end

  assign launch = rden_q & aen_q & ~aen_prev_q & ~scan_mode;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    tag_pipe_d    = tag_pipe_q;
    vld_pipe_d[0] = launch;
    tag_pipe_d[0] = launch ? tag_q : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  assign exit_vld = vld_pipe_q[RD_LAT-1];
  assign exit_tag = tag_pipe_q[RD_LAT-1];

  // Capture still happens under scan so in-flight reads are not lost.
  always_comb begin
    rdata_d     = rdata_q;
    rg_rdata_d  = rg_rdata_q;
    rvalid_d    = '0;
    rg_rvalid_d = 1'b0;
    if (exit_vld) begin
      if (tag_is_reg(exit_tag)) begin
        rg_rdata_d  = efuse_rdata_i;
        rg_rvalid_d = 1'b1;
      end else begin
        rdata_d  = efuse_rdata_i;
        rvalid_d = NCH'(1) << exit_tag[TAG_W-2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      gnt_q       <= '0;
      gap_cnt_q   <= '0;
      pgmen_q     <= 1'b0;
      rden_q      <= 1'b0;
      aen_q       <= 1'b0;
      aen_prev_q  <= 1'b0;
      addr_q      <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
      rdata_q     <= '0;
      rg_rdata_q  <= '0;
      rvalid_q    <= '0;
      rg_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pgmen_q     <= pgmen_d;
      rden_q      <= rden_d;
      aen_q       <= aen_d;
      aen_prev_q  <= aen_q;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      vld_pipe_q  <= vld_pipe_d;
      tag_pipe_q  <= tag_pipe_d;
      rdata_q     <= rdata_d;
      rg_rdata_q  <= rg_rdata_d;
      rvalid_q    <= rvalid_d;
      rg_rvalid_q <= rg_rvalid_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign rvalid_o      = rvalid_q;
  assign rg_rdata      = rg_rdata_q;
  assign rg_rvalid     = rg_rvalid_q;
  assign efuse_pgmen_o = pgmen_q & ~scan_mode;
  assign efuse_rden_o  = rden_q & ~scan_mode;
  assign efuse_aen_o   = aen_q & ~scan_mode;
  assign efuse_addr_o  = scan_mode ? '0 : addr_q;

endmodule

// File: tb/tb_efuse_arb.sv
// tb_efuse_arb: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model (queue of pending reads keyed by
// due cycle).
module tb_efuse_arb;

  localparam int NCH    = 2;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic              clk, rst_n, scan_mode;
  logic [NCH-1:0]    req_i, pgmen_i, rden_i, aen_i;
  logic [NCH*AW-1:0] addr_i;
  logic [NCH-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o, rg_rdata, efuse_rdata_i;
  logic              err_o, rg_reg_mode, rg_pgmen, rg_rden, rg_aen, rg_rvalid;
  logic [AW-1:0]     rg_addr, efuse_addr_o;
  logic              efuse_pgmen_o, efuse_rden_o, efuse_aen_o;

  efuse_arb #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .scan_mode(scan_mode),
    .req_i(req_i), .pgmen_i(pgmen_i), .rden_i(rden_i), .aen_i(aen_i),
    .addr_i(addr_i), .gnt_o(gnt_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .err_o(err_o), .rg_reg_mode(rg_reg_mode), .rg_pgmen(rg_pgmen),
    .rg_rden(rg_rden), .rg_aen(rg_aen), .rg_addr(rg_addr),
    .rg_rdata(rg_rdata), .rg_rvalid(rg_rvalid),
    .efuse_pgmen_o(efuse_pgmen_o), .efuse_rden_o(efuse_rden_o),
    .efuse_aen_o(efuse_aen_o), .efuse_addr_o(efuse_addr_o),
    .efuse_rdata_i(efuse_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int tag; } rd_t;  // tag -1 = register mode
  rd_t q[$];
  int  cyc;
  int  m_state;          // 0 idle, 1 grant, 2 reg, 3 gap
  int  m_owner, m_next, m_tag;
  bit [NCH-1:0] m_gnt, m_rvalid;
  bit  m_pg, m_rd, m_ae, m_ae_prev, m_err, m_rg_rvalid;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_rdata, m_rg_rdata;

  task automatic m_reset;
    q.delete();
    m_state = 0; m_owner = 0; m_next = 0; m_tag = 0;
    m_gnt = '0; m_rvalid = '0; m_rg_rvalid = 0;
    m_pg = 0; m_rd = 0; m_ae = 0; m_ae_prev = 0; m_err = 0;
    m_addr = '0; m_rdata = '0; m_rg_rdata = '0;
  endtask

  task automatic m_edge;
    bit s_pg, s_rd, s_ae, launch;
    bit [AW-1:0] s_addr;
    int s_tag, pick;
    rd_t e;
    s_pg = 0; s_rd = 0; s_ae = 0; s_addr = '0; s_tag = 0;
    if (m_state == 1) begin
      s_pg = pgmen_i[m_owner]; s_rd = rden_i[m_owner]; s_ae = aen_i[m_owner];
      s_addr = addr_i[m_owner*AW +: AW]; s_tag = m_owner;
    end else if (m_state == 2) begin
      s_pg = rg_pgmen; s_rd = rg_rden; s_ae = rg_aen; s_addr = rg_addr; s_tag = -1;
    end
    launch = m_rd && m_ae && !m_ae_prev && !scan_mode;
    m_rvalid = '0; m_rg_rvalid = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.tag < 0) begin m_rg_rdata = efuse_rdata_i; m_rg_rvalid = 1; end
      else begin m_rdata = efuse_rdata_i; m_rvalid[e.tag] = 1'b1; end
    end
    if (launch) q.push_back('{cyc + RD_LAT, m_tag});
    m_ae_prev = m_ae;
    m_err = s_pg && s_rd;
    m_pg  = s_pg && !m_err;
    m_rd  = s_rd && !m_err;
    m_ae  = s_ae; m_addr = s_addr; m_tag = s_tag;
    case (m_state)
      0: if (rg_reg_mode) m_state = 2;
         else if (req_i != '0) begin
           pick = -1;
           for (int k = 0; k < NCH; k++) begin
             int c;
             c = (m_next + k) % NCH;
             if (pick < 0 && req_i[c]) pick = c;
           end
           m_owner = pick; m_next = (pick + 1) % NCH;
           m_gnt = '0; m_gnt[pick] = 1'b1; m_state = 1;
         end
      1: if (!req_i[m_owner]) begin m_state = 3; m_gnt = '0; end
      2: if (!rg_reg_mode) m_state = 3;
      default: m_state = 0;
    endcase
    cyc++;
  endtask

  task automatic cmp_all;
    chk("gnt",       32'(gnt_o),         32'(m_gnt));
    chk("rvalid",    32'(rvalid_o),      32'(m_rvalid));
    chk("rdata",     32'(rdata_o),       32'(m_rdata));
    chk("rg_rvalid", 32'(rg_rvalid),     32'(m_rg_rvalid));
    chk("rg_rdata",  32'(rg_rdata),      32'(m_rg_rdata));
    chk("err",       32'(err_o),         32'(m_err));
    chk("efuse_pg",  32'(efuse_pgmen_o), 32'(m_pg && !scan_mode));
    chk("efuse_rd",  32'(efuse_rden_o),  32'(m_rd && !scan_mode));
    chk("efuse_ae",  32'(efuse_aen_o),   32'(m_ae && !scan_mode));
    chk("efuse_ad",  32'(efuse_addr_o),  32'(scan_mode ? '0 : m_addr));
  endtask

  // Inputs are set at the falling edge before calling; the model advances,
  // the DUT sees the rising edge, outputs are compared at the next fall.
  task automatic step;
    if (!rst_n) m_reset(); else m_edge();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    cyc = 0;
    m_reset();
    rst_n = 0; scan_mode = 0; req_i = '0; pgmen_i = '0; rden_i = '0; aen_i = '0;
    addr_i = 16'hB7A4; rg_reg_mode = 0; rg_pgmen = 0; rg_rden = 0; rg_aen = 0;
    rg_addr = '0; efuse_rdata_i = '0;
    @(negedge clk);
    step(); step();
    rst_n = 1;

    // round-robin hand-over through one gap cycle
    req_i = 2'b11; step();
    chk("rr_first", 32'(gnt_o), 32'h1);
    step();
    req_i = 2'b10; step();
    chk("gap_gnt", 32'(gnt_o), 32'h0);
    step(); step();
    chk("rr_next", 32'(gnt_o), 32'h2);

    // channel 1 read, data A5 presented RD_LAT cycles after launch
    rden_i = 2'b10; aen_i = 2'b00; efuse_rdata_i = 8'h11; step();
    aen_i = 2'b10; step();
    chk("rd_launch_aen", 32'(efuse_aen_o), 32'h1);
    chk("rd_launch_addr", 32'(efuse_addr_o), 32'hB7);
    step(); step();
    efuse_rdata_i = 8'hA5; step();
    chk("rd_data", 32'(rdata_o), 32'hA5);
    chk("rd_vld", 32'(rvalid_o), 32'h2);
    efuse_rdata_i = 8'h22; step();
    chk("rd_vld_pulse", 32'(rvalid_o), 32'h0);
    chk("rd_data_hold", 32'(rdata_o), 32'hA5);

    // illegal pgmen+rden
    pgmen_i = 2'b10; rden_i = 2'b10; step();
    chk("illegal_err", 32'(err_o), 32'h1);
    chk("illegal_pg", 32'(efuse_pgmen_o), 32'h0);
    chk("illegal_rd", 32'(efuse_rden_o), 32'h0);
    pgmen_i = '0; rden_i = '0; aen_i = '0; step();
    chk("illegal_err_pulse", 32'(err_o), 32'h0);

    // scan during an active read
    rden_i = 2'b10; step();
    aen_i = 2'b10; step();
    step();
    scan_mode = 1; aen_i = 2'b00; step();
    chk("scan_aen", 32'(efuse_aen_o), 32'h0);
    chk("scan_rden", 32'(efuse_rden_o), 32'h0);
    efuse_rdata_i = 8'h5A; aen_i = 2'b10; step();
    chk("scan_inflight_data", 32'(rdata_o), 32'h5A);
    chk("scan_inflight_vld", 32'(rvalid_o), 32'h2);
    efuse_rdata_i = 8'h33;
    repeat (3) begin step(); chk("scan_no_launch", 32'(rvalid_o), 32'h0); end
    scan_mode = 0; rden_i = '0; aen_i = '0;

    // register mode waits for the channel owner
    req_i = 2'b01; step(); step(); step();
    chk("rr_wrap", 32'(gnt_o), 32'h1);
    rg_reg_mode = 1; rg_addr = 8'h3C; step(); step();
    chk("no_preempt", 32'(gnt_o), 32'h1);
    req_i = '0; step(); step(); step(); step();
    chk("reg_addr", 32'(efuse_addr_o), 32'h3C);
    rg_reg_mode = 0; step(); step();

    // reset mid-grant with a read in flight
    req_i = 2'b11; step();
    chk("rr_ptr", 32'(gnt_o), 32'h2);
    rden_i = 2'b10; step();
    aen_i = 2'b10; step();
    step();
    rst_n = 0; #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_aen", 32'(efuse_aen_o), 32'h0);
    chk("rst_rden", 32'(efuse_rden_o), 32'h0);
    rden_i = '0; aen_i = '0;
    @(negedge clk);
    step(); step();
    rst_n = 1; step();
    chk("rst_rr", 32'(gnt_o), 32'h1);
    repeat (3) begin step(); chk("rst_no_rvalid", 32'(rvalid_o), 32'h0); end
    req_i = '0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NCH; k++) if ($urandom_range(15) == 0) req_i[k] = ~req_i[k];
      if ($urandom_range(39) == 0) rg_reg_mode = ~rg_reg_mode;
      if (scan_mode) begin
        if ($urandom_range(3) == 0) scan_mode = 0;
      end else if ($urandom_range(49) == 0) scan_mode = 1;
      for (int k = 0; k < NCH; k++) pgmen_i[k] = ($urandom_range(7) == 0);
      rden_i        = NCH'($urandom);
      aen_i         = NCH'($urandom);
      addr_i        = (NCH*AW)'($urandom);
      rg_pgmen      = ($urandom_range(7) == 0);
      rg_rden       = 1'($urandom_range(1));
      rg_aen        = 1'($urandom_range(1));
      rg_addr       = AW'($urandom);
      efuse_rdata_i = DW'($urandom);
      rst_n         = ($urandom_range(499) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/efuse_arb.md
EFUSE_ARB -- requirements
Module: efuse_arb

Interface
REQ-001 Parameter NCH, default 2: number of RTL requester channels, 1..8.
REQ-002 Parameter AW, default 8: efuse address width.
REQ-003 Parameter DW, default 8: efuse read data width.
REQ-004 Parameter RD_LAT, default 2: cycles from a registered read-strobe edge to valid efuse_rdata_i, 1..4.
REQ-005 Ports are listed one per line as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_mode  in  1  forces all efuse_* outputs to 0 and blocks sampling.
- req_i  in  NCH  per-channel access request, level.
- pgmen_i, rden_i, aen_i  in  NCH each  per-channel strobes.
- addr_i  in  NCH*AW  per-channel address; channel k is bits [k*AW +: AW].
- gnt_o  out  NCH  one-hot grant, registered.
- rdata_o  out  DW  captured read data, shared by all channels.
- rvalid_o  out  NCH  one-cycle pulse to the owning channel when rdata_o updates.
- err_o  out  1  one-cycle pulse on an illegal strobe combination.
- rg_reg_mode, rg_pgmen, rg_rden, rg_aen  in  1 each  register-mode override.
- rg_addr  in  AW  register-mode address.
- rg_rdata  out  DW  register-mode capture.
- rg_rvalid  out  1  register-mode capture pulse.
- efuse_pgmen_o, efuse_rden_o, efuse_aen_o  out  1 each  registered macro strobes.
- efuse_addr_o  out  AW  registered macro address.
- efuse_rdata_i  in  DW  macro read data.

Function
REQ-006 The FSM SHALL have four states: IDLE, GRANT, REG and GAP.
REQ-007 In IDLE with rg_reg_mode=1, the FSM SHALL enter REG; rg_reg_mode takes priority over every req_i.
REQ-008 In IDLE with any req_i set and rg_reg_mode=0, the FSM SHALL grant the next requester round-robin after the last owner, enter GRANT, and assert gnt_o the following cycle.
REQ-009 GRANT SHALL hold while the owner's req_i=1; when it deasserts, the FSM SHALL go to GAP and clear gnt_o.
REQ-010 rg_reg_mode asserting during GRANT SHALL NOT pre-empt the owner; it is served at the next IDLE.
REQ-011 REG SHALL hold while rg_reg_mode=1, then go to GAP.
REQ-012 GAP SHALL last exactly one cycle with all selected strobes 0, then return to IDLE.
REQ-013 The selected strobes and address SHALL be the owner's in GRANT, the rg_* inputs in REG, and 0 otherwise.
REQ-014 The selected strobes and address SHALL be registered once onto efuse_*_o, giving one cycle of latency.
REQ-015 If the selected pgmen and rden are both 1, both SHALL be forced to 0 before the output register and err_o SHALL pulse.
REQ-016 A read launch is a cycle where the registered efuse_rden_o=1 and efuse_aen_o rises 0->1.
REQ-017 Each launch SHALL push an owner tag (channel index or REG) into an RD_LAT-deep shift pipeline.
REQ-018 When a tag exits the pipeline, efuse_rdata_i SHALL be captured into rdata_o (channel owner) or rg_rdata (REG owner), and the matching rvalid_o bit or rg_rvalid SHALL pulse one cycle.
REQ-019 Launches on consecutive aen rising edges SHALL each produce a capture; the pipeline never drops a tag.
REQ-020 Tags already in flight SHALL complete after ownership changes.
REQ-021 scan_mode=1 SHALL force efuse_*_o to 0 combinationally, suppress new launches, and leave the FSM running.
REQ-022 rdata_o and rg_rdata SHALL hold their value until the next capture.

Reset
REQ-023 On rst_n low, the FSM SHALL enter IDLE.
REQ-024 On rst_n low, the round-robin pointer SHALL select channel 0 as next.
REQ-025 On rst_n low, gnt_o, rvalid_o, rg_rvalid, err_o, all efuse_*_o, rdata_o, rg_rdata and the tag pipeline SHALL clear to 0.

Structure
REQ-026 Package efuse_pkg SHALL hold the state enum, the owner-tag typedef (clog2(NCH)+1 bits, MSB=REG) and the GAP length constant.
REQ-027 One sub-module, efuse_rr_arb (NCH-wide round-robin picker with pointer update on grant), SHALL be instantiated.

Verification
REQ-028 NCH=2, req_i=2'b11 from IDLE -> gnt_o=01; drop req_i[0] -> one GAP cycle -> gnt_o=10.
REQ-029 Channel 1 owner, rden=1, aen 0->1 with efuse_rdata_i=8'hA5 at the RD_LAT=2 cycle -> rdata_o=8'hA5, rvalid_o=2'b10 for one cycle.
REQ-030 rg_reg_mode=1 while channel 0 is granted -> no pre-emption; after channel 0 releases -> GAP -> REG, efuse_addr_o=rg_addr one cycle later.
REQ-031 Owner drives pgmen=1 and rden=1 -> efuse_pgmen_o=efuse_rden_o=0, err_o pulses once.
REQ-032 scan_mode=1 during an active read -> all efuse_*_o=0, no new rvalid_o; in-flight tag still captures.
REQ-033 rst_n asserted mid-GRANT with a tag in flight -> all outputs 0 next edge, no rvalid_o after release, first grant goes to channel 0.
